// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C master PHY: command codes, engine states and bit phases.
package i2c_pkg;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_WRITE,
        ST_WACK,
        ST_READ,
        ST_RACK
    } state_e;

    // Each bit slot is split into four equal phases.
    typedef enum logic [1:0] {
        P0,
        P1,
        P2,
        P3
    } phase_e;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period counter and phase sequencer for the I2C bit engine.
// clear_i parks the timer at P0/count 0; stall_i freezes it (slave clock stretching).
module i2c_quarter_timer
    import i2c_pkg::*;
#(
    parameter int  QUARTER = 32,
    localparam int CNT_W   = $clog2(QUARTER)
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clear_i,
    input  logic   stall_i,
    output phase_e phase_o,
    output logic   phase_end_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_e           phase_q, phase_d;
    logic             cnt_last;

    assign cnt_last = (cnt_q == CNT_W'(QUARTER - 1));

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear_i) begin
            cnt_d   = '0;
            phase_d = P0;
        end else if (!stall_i) begin
            if (cnt_last) begin
                cnt_d = '0;
                unique case (phase_q)
                    P0:      phase_d = P1;
                    P1:      phase_d = P2;
                    P2:      phase_d = P3;
                    default: phase_d = P0;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= P0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o     = phase_q;
    assign phase_end_o = cnt_last && !clear_i && !stall_i;

endmodule

// File: rtl/i2c_master_phy.sv
// Bit-level I2C master: one START/STOP/READ/WRITE command per handshake, open-drain pad enables.
// Optional slave clock stretching is compiled in with `define I2C_CLK_STRETCH_EN.
module i2c_master_phy
    import i2c_pkg::*;
#(
    parameter int QUARTER = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_i,
    input  logic [7:0] tx_byte_i,
    input  logic       rd_nack_i,
    output logic [7:0] rx_byte_o,
    output logic       nack_o,
    output logic       done_o,
    output logic       busy_o,
    input  logic       scl_i,
    output logic       scl_oe_o,
    input  logic       sda_i,
    output logic       sda_oe_o
);

    state_e     state_q, state_d;
    phase_e     phase;
    logic       phase_end, stall, bit_end, sample_pt, accept, byte_scl;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d, rx_q, rx_d;
    logic       rd_nack_q, rd_nack_d, nack_q, nack_d, done_q, done_d;
    logic       scl_hold_q, sda_hold_q;

    i2c_quarter_timer #(.QUARTER(QUARTER)) u_timer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (state_q == ST_IDLE),
        .stall_i     (stall),
        .phase_o     (phase),
        .phase_end_o (phase_end)
    );

`ifdef I2C_CLK_STRETCH_EN
    // A slave holding SCL low while we release it freezes the bit timing.
    assign stall = ((phase == P1) || (phase == P2)) && !scl_oe_o && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stall      = 1'b0;
`endif

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = !cmd_ready_o;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign bit_end     = phase_end && (phase == P3);
    assign sample_pt   = phase_end && (phase == P1);

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rd_nack_d = rd_nack_q;
        nack_d    = nack_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bit_d     = 3'd0;
                    tx_d      = tx_byte_i;
                    rd_nack_d = rd_nack_i;
                    case (cmd_i)
                        CMD_START: state_d = ST_START;
                        CMD_STOP:  state_d = ST_STOP;
                        CMD_READ:  state_d = ST_READ;
                        default:   state_d = ST_WRITE;
                    endcase
                end
            end
            ST_WRITE, ST_READ: begin
                if ((state_q == ST_READ) && sample_pt) begin
                    rx_d = {rx_q[6:0], sda_i};
                end
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (state_q == ST_WRITE) begin
                            state_d = ST_WACK;
                        end else begin
                            state_d = ST_RACK;
                        end
                    end
                end
            end
            ST_START, ST_STOP, ST_WACK, ST_RACK: begin
                if ((state_q == ST_WACK) && sample_pt) begin
                    nack_d = sda_i;
                end
                if (bit_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pad drive per state/phase; in IDLE the bus keeps whatever level the last command left.
    assign byte_scl = (phase == P0) || (phase == P3);

    always_comb begin
        scl_oe_o = scl_hold_q;
        sda_oe_o = sda_hold_q;
        case (state_q)
            ST_START: begin
                scl_oe_o = (phase == P2) || (phase == P3);
                sda_oe_o = (phase != P0);
            end
            ST_STOP: begin
                scl_oe_o = (phase == P0);
                sda_oe_o = (phase == P0) || (phase == P1);
            end
            ST_WRITE: begin
                scl_oe_o = byte_scl;
                sda_oe_o = !tx_q[3'd7 - bit_q];
            end
            ST_WACK, ST_READ: begin
                scl_oe_o = byte_scl;
                sda_oe_o = 1'b0;
            end
            ST_RACK: begin
                scl_oe_o = byte_scl;
                sda_oe_o = !rd_nack_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            bit_q      <= 3'd0;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            rd_nack_q  <= 1'b0;
            nack_q     <= 1'b0;
            done_q     <= 1'b0;
            scl_hold_q <= 1'b0;
            sda_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rd_nack_q  <= rd_nack_d;
            nack_q     <= nack_d;
            done_q     <= done_d;
            scl_hold_q <= scl_oe_o;
            sda_hold_q <= sda_oe_o;
        end
    end

    assign rx_byte_o = rx_q;
    assign nack_o    = nack_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_i2c_master_phy.sv
// Self-checking bench for i2c_master_phy: directed command table, reset/stretch sequences,
// and a random command stream checked against bus-level expectations.
module tb_i2c_master_phy;
    import i2c_pkg::*;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] tx_byte = 8'h00;
    logic       rd_nack = 1'b0;
    logic       cmd_ready, nack, done, busy, scl_oe, sda_oe;
    logic [7:0] rx_byte;
    logic       slavePull = 1'b0;
    logic       stretchPull = 1'b0;
    logic       sclLine, sdaLine;

    assign sclLine = ~(scl_oe | stretchPull);
    assign sdaLine = ~(sda_oe | slavePull);

    i2c_master_phy #(.QUARTER(Q)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_i       (cmd),
        .tx_byte_i   (tx_byte),
        .rd_nack_i   (rd_nack),
        .rx_byte_o   (rx_byte),
        .nack_o      (nack),
        .done_o      (done),
        .busy_o      (busy),
        .scl_i       (sclLine),
        .scl_oe_o    (scl_oe),
        .sda_i       (sdaLine),
        .sda_oe_o    (sda_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] data;
        logic       flag;
        int         glitchAt;
        int         stretchBit;
        int         expLat;
        logic       expNack;
        logic [7:0] expRx;
        int         expFallHigh;
        int         expRiseHigh;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   fallCount = 0;
    int   fallHigh = 0;
    int   riseHigh = 0;
    int   slaveMode = 0;
    logic [7:0] slaveByte = 8'h00;
    logic slaveAck = 1'b0;
    logic prevScl = 1'b1;
    logic prevSda = 1'b1;
    logic dataOe = 1'b0;
    logic rackOe = 1'b0;
    bit   sampQ[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Slave: mode 1 acks a written byte, mode 2 returns slaveByte; data moves after each SCL fall.
    function automatic logic slaveDrive();
        if (slaveMode == 1) return slaveAck && (fallCount == 8);
        if (slaveMode == 2 && fallCount < 8) return ~slaveByte[3'(7 - fallCount)];
        return 1'b0;
    endfunction

    task automatic stepCycle();
        logic sclNow;
        @(negedge clk);
        sclNow = ~scl_oe;
        if (sclNow && !prevScl) sampQ.push_back(sdaLine);
        if (!sclNow && prevScl) fallCount++;
        if (prevScl && sclNow && prevSda && !sdaLine) fallHigh++;
        if (prevScl && sclNow && !prevSda && sdaLine) riseHigh++;
        if (fallCount < 8 && sda_oe) dataOe = 1'b1;
        if (fallCount == 8 && sda_oe) rackOe = 1'b1;
        prevScl   = sclNow;
        prevSda   = sdaLine;
        slavePull = slaveDrive();
    endtask

    task automatic applyStimulus(input vec_t v, output int lat, output bit midBusy);
        int  holdLeft;
        bit  stretched;
        sampQ.delete();
        fallCount = 0; fallHigh = 0; riseHigh = 0; dataOe = 1'b0; rackOe = 1'b0;
        slaveMode = (v.cmd == CMD_WRITE) ? 1 : (v.cmd == CMD_READ) ? 2 : 0;
        slaveByte = v.data;
        slaveAck  = v.flag;
        slavePull = slaveDrive();
        cmd_valid = 1'b1; cmd = v.cmd; tx_byte = v.data; rd_nack = v.flag;
        stepCycle();
        cmd_valid = 1'b0; tx_byte = ~v.data; rd_nack = ~v.flag;
        lat = 0; midBusy = 1'b0; holdLeft = 0; stretched = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) break;
            if (lat == 2) midBusy = busy && !cmd_ready;
            if (lat == v.glitchAt) begin
                cmd_valid = 1'b1; cmd = CMD_STOP;
            end else begin
                cmd_valid = 1'b0;
            end
            if (holdLeft > 0) begin
                holdLeft--;
                if (holdLeft == 0) stretchPull = 1'b0;
            end else if (v.stretchBit >= 0 && !stretched && fallCount == v.stretchBit && !scl_oe) begin
                stretchPull = 1'b1; stretched = 1'b1; holdLeft = 20;
            end
            lat++;
            stepCycle();
        end
        cmd_valid = 1'b0;
        stretchPull = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input string vn);
        int         lat;
        bit         midBusy;
        logic [7:0] got;
        int         ackBit;
        checkOutput({vn, ".ready_before"}, 32'(cmd_ready), 32'd1);
        applyStimulus(v, lat, midBusy);
        checkOutput({vn, ".latency"}, 32'(lat), 32'(v.expLat));
        checkOutput({vn, ".busy_mid"}, 32'(midBusy), 32'd1);
        checkOutput({vn, ".busy_at_done"}, 32'(busy), 32'd0);
        checkOutput({vn, ".start_cond"}, 32'(fallHigh), 32'(v.expFallHigh));
        checkOutput({vn, ".stop_cond"}, 32'(riseHigh), 32'(v.expRiseHigh));
        if (v.cmd == CMD_WRITE) begin
            got = 8'h00;
            for (int k = 0; k < 8 && k < sampQ.size(); k++) got = {got[6:0], sampQ[k]};
            ackBit = (sampQ.size() > 8) ? int'(sampQ[8]) : -1;
            checkOutput({vn, ".sda_bits"}, 32'(got), 32'(v.data));
            checkOutput({vn, ".ack_bit"}, 32'(ackBit), 32'(!v.flag));
            checkOutput({vn, ".nack"}, 32'(nack), 32'(v.expNack));
        end
        if (v.cmd == CMD_READ) begin
            checkOutput({vn, ".rx_byte"}, 32'(rx_byte), 32'(v.expRx));
            checkOutput({vn, ".sda_oe_data"}, 32'(dataOe), 32'd0);
            checkOutput({vn, ".sda_oe_rack"}, 32'(rackOe), 32'(!v.flag));
        end
        stepCycle();
        checkOutput({vn, ".done_pulse"}, 32'(done), 32'd0);
        checkOutput({vn, ".ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    // Reference rules: control commands take 4 quarters, bytes 36; START/STOP make exactly one bus condition.
    function automatic vec_t makeVec(input logic [1:0] c, input logic [7:0] d, input logic f);
        vec_t v;
        v.cmd = c; v.data = d; v.flag = f; v.glitchAt = -1; v.stretchBit = -1;
        v.expLat      = (c == CMD_START || c == CMD_STOP) ? 4 * Q : 36 * Q;
        v.expNack     = (c == CMD_WRITE) ? !f : 1'b0;
        v.expRx       = d;
        v.expFallHigh = (c == CMD_START) ? 1 : 0;
        v.expRiseHigh = (c == CMD_STOP) ? 1 : 0;
        return v;
    endfunction

    vec_t table_v[10];

    initial begin
        vec_t v;
        int   r;
        table_v[0] = '{CMD_START, 8'h00, 1'b0, -1, -1, 16,  1'b0, 8'h00, 1, 0};
        table_v[1] = '{CMD_WRITE, 8'hA5, 1'b1, -1, -1, 144, 1'b0, 8'h00, 0, 0};
        table_v[2] = '{CMD_WRITE, 8'h3C, 1'b0, -1, -1, 144, 1'b1, 8'h00, 0, 0};
        table_v[3] = '{CMD_READ,  8'hC3, 1'b1, -1, -1, 144, 1'b0, 8'hC3, 0, 0};
        table_v[4] = '{CMD_STOP,  8'h00, 1'b0, -1, -1, 16,  1'b0, 8'h00, 0, 1};
        table_v[5] = '{CMD_START, 8'h00, 1'b0, -1, -1, 16,  1'b0, 8'h00, 1, 0};
        table_v[6] = '{CMD_READ,  8'h5A, 1'b0, -1, -1, 144, 1'b0, 8'h5A, 0, 0};
        table_v[7] = '{CMD_START, 8'h00, 1'b0, -1, -1, 16,  1'b0, 8'h00, 1, 0};
        table_v[8] = '{CMD_WRITE, 8'h96, 1'b1, 50, -1, 144, 1'b0, 8'h00, 0, 0};
        table_v[9] = '{CMD_STOP,  8'h00, 1'b0, -1, -1, 16,  1'b0, 8'h00, 0, 1};

        repeat (3) stepCycle();
        checkOutput("reset.scl_oe", 32'(scl_oe), 32'd0);
        checkOutput("reset.sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.rx_byte", 32'(rx_byte), 32'h00);
        checkOutput("reset.nack", 32'(nack), 32'd0);
        rst_n = 1'b1;
        stepCycle();

        for (int i = 0; i < 10; i++) runVector(table_v[i], $sformatf("table%0d", i));

        // Reset in the middle of bit 3 of a WRITE must release both lines at once.
        runVector(makeVec(CMD_START, 8'h00, 1'b0), "rst_start");
        v = makeVec(CMD_WRITE, 8'h00, 1'b1);
        sampQ.delete(); fallCount = 0; slaveMode = 1; slaveAck = 1'b1;
        cmd_valid = 1'b1; cmd = CMD_WRITE; tx_byte = 8'h00;
        stepCycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 300 && fallCount < 3; i++) stepCycle();
        repeat (Q) stepCycle();
        checkOutput("midrst.scl_oe_before", 32'(scl_oe), 32'd1);
        checkOutput("midrst.sda_oe_before", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.scl_oe", 32'(scl_oe), 32'd0);
        checkOutput("midrst.sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("midrst.busy", 32'(busy), 32'd0);
        checkOutput("midrst.rx_byte", 32'(rx_byte), 32'h00);
        slaveMode = 0; slavePull = 1'b0;
        repeat (2) stepCycle();
        rst_n = 1'b1;
        stepCycle();
        checkOutput("midrst.ready", 32'(cmd_ready), 32'd1);

`ifdef I2C_CLK_STRETCH_EN
        runVector(makeVec(CMD_START, 8'h00, 1'b0), "stretch_start");
        v = makeVec(CMD_WRITE, 8'h96, 1'b1);
        v.stretchBit = 2;
        v.expLat = v.expLat + 20;
        runVector(v, "stretch_write");
        runVector(makeVec(CMD_STOP, 8'h00, 1'b0), "stretch_stop");
`endif

        runVector(makeVec(CMD_START, 8'h00, 1'b0), "rand_start");
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                runVector(makeVec(CMD_WRITE, 8'($urandom), 1'($urandom_range(0, 1))), $sformatf("rand%0d_wr", i));
            end else if (r < 8) begin
                runVector(makeVec(CMD_READ, 8'($urandom), 1'($urandom_range(0, 1))), $sformatf("rand%0d_rd", i));
            end else if (r == 8) begin
                runVector(makeVec(CMD_START, 8'h00, 1'b0), $sformatf("rand%0d_rstart", i));
            end else begin
                runVector(makeVec(CMD_STOP, 8'h00, 1'b0), $sformatf("rand%0d_stop", i));
                runVector(makeVec(CMD_START, 8'h00, 1'b0), $sformatf("rand%0d_start", i));
            end
        end
        runVector(makeVec(CMD_STOP, 8'h00, 1'b0), "rand_final_stop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
